// File: rtl/imem_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : imem_loader_if                                              |
// | Description : Boot-stream and instruction-memory write bundle for the     |
// |               imem loader.                                                |
// |   in_data/in_valid/in_ready : byte stream in (valid/ready handshake)      |
// |   wr_en/wr_addr/wr_data     : single-cycle instruction-memory write       |
// |   master : loader side      slave : stream source / memory side          |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
interface imem_loader_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport master (
    input  in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data
  );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : imem_loader                                                 |
// | Description : Boot-time instruction-memory writer. Takes a 16-bit LE word |
// |               count followed by the payload bytes, packs every 4 bytes    |
// |               into an LE 32-bit word written from address 0 upwards, and  |
// |               holds the core in reset until the image is complete.        |
// |   clk, rst      : clock, asynchronous active-high reset                   |
// |   start         : re-arm pulse (honoured in DONE / ERR only)              |
// |   bus           : stream input + memory write port (master modport)       |
// |   cpu_rst       : core reset hold, low only in DONE                       |
// |   done, err     : status flags                                            |
// |   words_written : words written by the current load                       |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  wire                clk,
  input  wire                rst,
  input  wire                start,
  imem_loader_if.master      bus,
  output logic               cpu_rst,
  output logic               done,
  output logic               err,
  output logic [ADDR_W:0]    words_written
);

  // Length comparisons are carried out at the wider of the two widths so
  // neither the 16-bit count nor the capacity is ever truncated.
  localparam int CMP_W = (ADDR_W + 1 > 16) ? ADDR_W + 1 : 16;
  localparam logic [CMP_W-1:0] C_CAPACITY = CMP_W'(1) << ADDR_W;

  typedef enum logic [2:0] {
    LEN_LO  = 3'd0,
    LEN_HI  = 3'd1,
    DATA    = 3'd2,
    DONE_ST = 3'd3,
    ERR_ST  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic              r_in_ready;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [31:0]       r_wr_data;
  logic [ADDR_W:0]   r_words;
  logic [15:0]       r_len;
  logic [1:0]        r_byte_idx;
  logic [23:0]       r_asm;          // bytes 0..2 of the word in progress

  logic              w_accept;
  logic              w_write_word;
  logic              w_last_word;
  logic [CMP_W-1:0]  w_len_full;     // count as seen on the LEN_HI transfer

  assign w_accept    = r_in_ready & bus.in_valid;
  assign w_len_full  = CMP_W'({bus.in_data, r_len[7:0]});
  assign w_last_word = (CMP_W'(r_words) + CMP_W'(1)) == CMP_W'(r_len);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= LEN_LO;
    else     r_state <= w_next_state;
  end

  // Next-state and status decode
  always_comb begin
    w_next_state = r_state;
    w_write_word = 1'b0;
    cpu_rst      = 1'b1;
    done         = 1'b0;
    err          = 1'b0;
    case (r_state)
      LEN_LO: begin
        if (w_accept) w_next_state = LEN_HI;
      end
      LEN_HI: begin
        if (w_accept) begin
          if (w_len_full == '0)              w_next_state = DONE_ST;
          else if (w_len_full > C_CAPACITY)  w_next_state = ERR_ST;
          else                               w_next_state = DATA;
        end
      end
      DATA: begin
        if (w_accept && r_byte_idx == 2'd3) begin
          w_write_word = 1'b1;
          // The final write and the DONE entry share the same edge.
          if (w_last_word) w_next_state = DONE_ST;
        end
      end
      DONE_ST: begin
        cpu_rst = 1'b0;
        done    = 1'b1;
        if (start) w_next_state = LEN_LO;
      end
      ERR_ST: begin
        err = 1'b1;
        if (start) w_next_state = LEN_LO;
      end
      default: w_next_state = LEN_LO;
    endcase
  end

  // Datapath. in_ready is registered from the next state so it stays low
  // throughout reset and rises on the first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_ready <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_words    <= '0;
      r_len      <= '0;
      r_byte_idx <= '0;
      r_asm      <= '0;
    end else begin
      r_in_ready <= (w_next_state == LEN_LO) || (w_next_state == LEN_HI) ||
                    (w_next_state == DATA);
      r_wr_en    <= w_write_word;

      if (r_state == LEN_LO && w_accept) r_len[7:0]  <= bus.in_data;
      if (r_state == LEN_HI && w_accept) r_len[15:8] <= bus.in_data;

      if (r_state == DATA && w_accept) begin
        r_byte_idx <= r_byte_idx + 2'd1;
        case (r_byte_idx)
          2'd0:    r_asm[7:0]   <= bus.in_data;
          2'd1:    r_asm[15:8]  <= bus.in_data;
          2'd2:    r_asm[23:16] <= bus.in_data;
          default: ;             // byte 3 goes straight into wr_data
        endcase
      end

      if (w_write_word) begin
        r_wr_addr <= r_words[ADDR_W-1:0];
        r_wr_data <= {bus.in_data, r_asm};
        r_words   <= r_words + (ADDR_W + 1)'(1);
      end

      if ((r_state == DONE_ST || r_state == ERR_ST) && start) begin
        r_words    <= '0;
        r_byte_idx <= '0;
        r_asm      <= '0;
        r_len      <= '0;
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.wr_en     = r_wr_en;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;
  assign words_written = r_words;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_imem_loader                                              |
// | Description : Self-checking bench for imem_loader: a cycle table for the  |
// |               basic two-word image, then directed sequences for stretched |
// |               handshakes, zero/oversize/full-size lengths and a mid-load  |
// |               asynchronous reset.                                         |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module tb_imem_loader;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              cpu_rst;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_written;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .bus           (bus),
    .cpu_rst       (cpu_rst),
    .done          (done),
    .err           (err),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  // Write monitor, sampled on the falling edge
  logic [ADDR_W-1:0] q_addr[$];
  logic [31:0]       q_data[$];
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      q_addr.push_back(bus.wr_addr);
      q_data.push_back(bus.wr_data);
    end
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_q();
    q_addr.delete();
    q_data.delete();
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'(i) * 32'h9E3779B1;
  endfunction

  typedef struct {
    logic              valid;
    logic [7:0]        data;
    logic              rdy;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              dn;
    logic              crst;
    logic              er;
    logic [ADDR_W:0]   ww;
  } vec_t;

  vec_t vec[12];

  initial begin
    logic [7:0]  img[10];
    logic [57:0] act_v;
    logic [57:0] exp_v;
    int          bad;
    logic [31:0] w;

    // Cycle table for the basic image: inputs before an edge, outputs after it
    vec[0]  = '{1'b1, 8'h02, 1'b1, 1'b0, 10'd0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 11'd0};
    vec[1]  = '{1'b1, 8'h00, 1'b1, 1'b0, 10'd0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 11'd0};
    vec[2]  = '{1'b1, 8'h13, 1'b1, 1'b0, 10'd0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 11'd0};
    vec[3]  = '{1'b1, 8'h00, 1'b1, 1'b0, 10'd0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 11'd0};
    vec[4]  = '{1'b1, 8'h00, 1'b1, 1'b0, 10'd0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 11'd0};
    vec[5]  = '{1'b1, 8'h00, 1'b1, 1'b1, 10'd0, 32'h0000_0013, 1'b0, 1'b1, 1'b0, 11'd1};
    vec[6]  = '{1'b1, 8'h93, 1'b1, 1'b0, 10'd0, 32'h0000_0013, 1'b0, 1'b1, 1'b0, 11'd1};
    vec[7]  = '{1'b1, 8'h00, 1'b1, 1'b0, 10'd0, 32'h0000_0013, 1'b0, 1'b1, 1'b0, 11'd1};
    vec[8]  = '{1'b1, 8'h10, 1'b1, 1'b0, 10'd0, 32'h0000_0013, 1'b0, 1'b1, 1'b0, 11'd1};
    vec[9]  = '{1'b1, 8'h00, 1'b0, 1'b1, 10'd1, 32'h0010_0093, 1'b1, 1'b0, 1'b0, 11'd2};
    vec[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 10'd1, 32'h0010_0093, 1'b1, 1'b0, 1'b0, 11'd2};
    vec[11] = '{1'b1, 8'h55, 1'b0, 1'b0, 10'd1, 32'h0010_0093, 1'b1, 1'b0, 1'b0, 11'd2};

    img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

    rst          = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // ---- reset state
    repeat (3) tick();
    check("reset_outputs",
          {bus.in_ready, bus.wr_en, bus.wr_addr, bus.wr_data, done, cpu_rst, err, words_written},
          {1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b1, 1'b0, 11'd0});
    rst = 1'b0;
    tick();
    check("ready_after_release", bus.in_ready, 1'b1);

    // ---- test 1: table-driven basic image at 1 byte/cycle
    for (int i = 0; i < 12; i++) begin
      bus.in_data  = vec[i].data;
      bus.in_valid = vec[i].valid;
      tick();
      act_v = {bus.in_ready, bus.wr_en, bus.wr_addr, bus.wr_data, done, cpu_rst, err, words_written};
      exp_v = {vec[i].rdy, vec[i].we, vec[i].addr, vec[i].wdata, vec[i].dn, vec[i].crst,
               vec[i].er, vec[i].ww};
      check($sformatf("basic_vec%0d", i), 64'(act_v), 64'(exp_v));
    end
    bus.in_valid = 1'b0;

    // ---- test 2: same image, in_valid toggling
    pulse_start();
    check("rearm_from_done", {bus.in_ready, done, cpu_rst, err, words_written},
          {1'b1, 1'b0, 1'b1, 1'b0, 11'd0});
    clear_q();
    for (int i = 0; i < 10; i++) begin
      send_byte(img[i]);
      tick();
    end
    check("toggle_nwrites", q_addr.size(), 2);
    if (q_addr.size() == 2) begin
      check("toggle_w0", {q_addr[0], q_data[0]}, {10'd0, 32'h0000_0013});
      check("toggle_w1", {q_addr[1], q_data[1]}, {10'd1, 32'h0010_0093});
    end
    check("toggle_final", {done, cpu_rst, words_written}, {1'b1, 1'b0, 11'd2});

    // ---- test 3: zero length
    pulse_start();
    clear_q();
    send_byte(8'h00);
    send_byte(8'h00);
    check("len0_done", {bus.in_ready, bus.wr_en, done, cpu_rst, err, words_written},
          {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 11'd0});
    repeat (2) tick();
    check("len0_nwrites", q_addr.size(), 0);

    // ---- test 4: one word over capacity
    pulse_start();
    clear_q();
    send_byte(8'h01);
    send_byte(8'h04);
    check("oversize_err", {bus.in_ready, done, cpu_rst, err}, {1'b0, 1'b0, 1'b1, 1'b1});
    bus.in_data  = 8'hEE;          // must not be consumed while in ERR
    bus.in_valid = 1'b1;
    repeat (2) tick();
    bus.in_valid = 1'b0;
    check("oversize_nwrites", q_addr.size(), 0);
    pulse_start();
    check("err_rearm", {bus.in_ready, err, done, cpu_rst}, {1'b1, 1'b0, 1'b0, 1'b1});

    // ---- test 5: exactly full capacity
    clear_q();
    send_byte(8'h00);
    send_byte(8'h04);
    check("full_enters_data", {bus.in_ready, err, done}, {1'b1, 1'b0, 1'b0});
    for (int i = 0; i < 1024; i++) begin
      w = pat(i);
      for (int k = 0; k < 4; k++) begin
        if (i == 1023 && k == 3)
          check("full_not_done_early", {done, words_written}, {1'b0, 11'd1023});
        send_byte(w[8*k +: 8]);
      end
    end
    check("full_final", {bus.wr_en, bus.wr_addr, done, cpu_rst, words_written},
          {1'b1, 10'd1023, 1'b1, 1'b0, 11'd1024});
    repeat (2) tick();
    check("full_nwrites", q_addr.size(), 1024);
    bad = 0;
    for (int i = 0; i < q_addr.size(); i++)
      if (q_addr[i] !== 10'(i) || q_data[i] !== pat(i)) bad++;
    check("full_contents_bad", bad, 0);

    // ---- test 6: asynchronous reset in the middle of word 1
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    send_byte(8'h66);
    check("midload_progress", words_written, 11'd1);
    #3 rst = 1'b1;                 // between edges
    #1;
    check("async_reset", {bus.in_ready, bus.wr_en, cpu_rst, done, words_written},
          {1'b0, 1'b0, 1'b1, 1'b0, 11'd0});
    tick();
    rst = 1'b0;
    clear_q();
    tick();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    send_byte(8'hDD);
    check("fresh_write", {bus.wr_en, bus.wr_addr, bus.wr_data, done, cpu_rst},
          {1'b1, 10'd0, 32'hDDCC_BBAA, 1'b1, 1'b0});
    repeat (2) tick();
    check("fresh_nwrites", q_addr.size(), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction memory that the rv32i core only reads.
- Accepts a byte stream over a valid/ready handshake: a 16-bit little-endian word count, then the payload.
- Packs each group of 4 payload bytes into a little-endian 32-bit word and writes it to consecutive word addresses from 0.
- Holds the core in reset until the image is fully loaded.

Parameters:
- ADDR_W, 10, instruction-memory word-address width; capacity = 2^ADDR_W words (1024 = 4 kB).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; from DONE or ERR, re-arms the loader for a new image. Ignored in other states.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader can take a byte; a byte transfers when in_valid & in_ready at a clock edge.
- wr_en  output  1  instruction-memory write strobe, one cycle per word.
- wr_addr  output  ADDR_W  word address of the write.
- wr_data  output  32  word to write.
- cpu_rst  output  1  core reset hold; high until a successful load completes.
- done  output  1  high in DONE.
- err  output  1  high in ERR.
- words_written  output  ADDR_W+1  number of words written in the current load.

Behaviour:
- States: LEN_LO, LEN_HI, DATA, DONE, ERR.
- Reset (asynchronous, takes effect immediately, including mid-load):
  - state = LEN_LO.
  - in_ready = 0 while rst is high, then 1 from the first edge after release.
  - wr_en = 0, wr_addr = 0, wr_data = 0.
  - cpu_rst = 1, done = 0, err = 0, words_written = 0.
  - Internal length, byte index (2 bits) and assembly register cleared; any partial word is discarded.
- in_ready = 1 in LEN_LO, LEN_HI and DATA; 0 in DONE and ERR. in_ready never depends on in_valid.
- LEN_LO: on transfer, latch len[7:0] and go to LEN_HI.
- LEN_HI: on transfer, latch len[15:8], then evaluate the full 16-bit len:
  - len == 0 → DONE.
  - len > 2^ADDR_W → ERR.
  - otherwise → DATA.
- DATA:
  - Byte k of each word (k = 0..3, order of arrival) is placed in bits [8k+7:8k].
  - On the transfer of byte 3, the next cycle shows wr_en = 1, wr_data = the assembled word, wr_addr = words_written (value before increment).
  - words_written increments in that same cycle.
  - Write latency: exactly 1 cycle after the 4th byte's accepting edge.
  - Back-to-back words at 1 byte/cycle give wr_en every 4th cycle. No backpressure from memory; writes always complete in one cycle.
  - When the write of word number len is issued, the state becomes DONE in the same cycle.
- wr_en is a single-cycle pulse and is never asserted outside the cycle following a 4th-byte transfer.
- wr_addr and wr_data hold their last values when wr_en = 0.
- DONE:
  - done = 1; cpu_rst falls to 0 in the first cycle DONE is entered.
  - Bytes are not accepted.
  - start → LEN_LO: clears words_written and the byte index, cpu_rst = 1 and done = 0 from the next cycle.
- ERR:
  - err = 1, cpu_rst stays 1, no memory writes occurred.
  - start → LEN_LO, clearing err.
- in_valid high while in_ready is low: no effect; the byte is not consumed.
- start in LEN_LO, LEN_HI or DATA: ignored.
- start coincident with rst: rst wins.
- Width rules:
  - len is 16 bits; the comparison against 2^ADDR_W is done at ADDR_W+1 or 16 bits, whichever is wider, with no truncation.
  - wr_addr = words_written[ADDR_W-1:0]; it never wraps because len ≤ 2^ADDR_W.

Test Plan:
1. Reset, then send 02 00 13 00 00 00 93 00 10 00 at 1 byte/cycle:
   - wr_en pulses at addr 0 with 0x00000013, then at addr 1 with 0x00100093, each 1 cycle after its 4th byte.
   - done = 1 and cpu_rst = 0 with the second write; in_ready = 0 afterwards.
2. Same image with in_valid toggling 1/0 every cycle:
   - Identical writes and data; only the timing stretches. No byte is dropped or duplicated.
3. Length 00 00:
   - DONE directly after the 2nd byte, no wr_en, words_written = 0, cpu_rst = 0.
4. Length 01 04 (0x0401 = 1025) with ADDR_W = 10:
   - ERR, err = 1, cpu_rst = 1, no wr_en, in_ready = 0.
   - start pulse → back in LEN_LO with err = 0 and in_ready = 1.
5. Length 0x0400 (1024), full payload:
   - Last write at addr 1023, words_written = 1024, done = 1.
6. Mid-DATA async reset after 2 payload bytes of word 1:
   - wr_en and in_ready go 0 immediately, cpu_rst = 1.
   - A fresh 01 00 AA BB CC DD writes 0xDDCCBBAA at addr 0; no stale bytes appear.
